// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM state encoding
// and the default start-of-frame marker.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into one little-endian 32-bit word; the first
// byte of a word lands in [7:0].
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  // The 4th byte is merged combinationally so the parent can register the
  // finished word on the same edge that accepts that byte.
  assign word_o       = {byte_i, sr_q};
  assign word_valid_o = strobe_i && (cnt_q == 2'd3);

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (strobe_i) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {byte_i, sr_q[23:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

endmodule

// File: rtl/inst_loader.sv
// Framed byte-stream program loader: writes 32-bit words into instruction
// memory and holds the core in reset until a frame's checksum is verified.
module inst_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  SOF_BYTE  = SOF_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        load_en,
  output logic [31:0] Inst_addr_load,
  output logic [31:0] Inst_load,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic        in_ready_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [7:0]  xor_q;
  logic        load_en_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        busy_q, done_q, err_q, core_rst_n_q;

  logic        acc;
  logic        sof_acc;
  logic        data_strobe;
  logic [15:0] len_n;
  logic        last_word;
  logic [31:0] word;
  logic        word_valid;

  assign acc         = in_valid && in_ready_q;
  assign data_strobe = acc && (state_q == ST_DATA);
  assign len_n       = {in_data, len_q[7:0]};
  assign last_word   = (idx_q == (len_q - 16'd1));

  word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (in_data),
    .strobe_i     (data_strobe),
    .clear_i      (sof_acc),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d = state_q;
    sof_acc = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (acc && (in_data == SOF_BYTE)) begin
          state_d = ST_LEN0;
          sof_acc = 1'b1;
        end
      end
      ST_LEN0: if (acc) state_d = ST_LEN1;
      ST_LEN1: begin
        if (acc) begin
          if (len_n > MAX_W16)      state_d = ST_ERR;
          else if (len_n == 16'd0) state_d = ST_CHK;
          else                     state_d = ST_DATA;
        end
      end
      ST_DATA: if (word_valid && last_word) state_d = ST_CHK;
      ST_CHK: begin
        if (acc) state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      len_q        <= 16'd0;
      idx_q        <= 16'd0;
      xor_q        <= 8'd0;
      load_en_q    <= 1'b0;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= 1'b1;
      load_en_q  <= word_valid;
      if (word_valid) begin
        addr_q <= BASE_ADDR + {14'd0, idx_q, 2'b00};
        data_q <= word;
        idx_q  <= idx_q + 16'd1;
      end
      if (sof_acc) begin
        idx_q <= 16'd0;
        xor_q <= 8'd0;
      end else if (acc && (state_q inside {ST_LEN0, ST_LEN1, ST_DATA})) begin
        xor_q <= xor_q ^ in_data;
      end
      if (acc && (state_q == ST_LEN0)) len_q[7:0]  <= in_data;
      if (acc && (state_q == ST_LEN1)) len_q[15:8] <= in_data;
      // Flags decode the next state so they rise together with the transition.
      busy_q       <= state_d inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CHK};
      done_q       <= (state_d == ST_DONE);
      err_q        <= (state_d == ST_ERR);
      core_rst_n_q <= (state_d == ST_DONE);
    end
  end

  assign in_ready       = in_ready_q;
  assign load_en        = load_en_q;
  assign Inst_addr_load = addr_q;
  assign Inst_load      = data_q;
  assign core_rst_n     = core_rst_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: two instances (base 0x0 and 0x100) share
// one byte stream; expected writes are queued as 4th data bytes are driven.
module tb_inst_loader;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready_a, load_en_a, core_rst_n_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, inst_a;
  logic        in_ready_b, load_en_b, core_rst_n_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, inst_b;

  always #5 clk = ~clk;

  inst_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(MAXW)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .load_en(load_en_a), .Inst_addr_load(addr_a),
    .Inst_load(inst_a), .core_rst_n(core_rst_n_a), .busy(busy_a),
    .done(done_a), .err(err_a)
  );

  inst_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(MAXW)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .load_en(load_en_b), .Inst_addr_load(addr_b),
    .Inst_load(inst_b), .core_rst_n(core_rst_n_b), .busy(busy_b),
    .done(done_b), .err(err_b)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_wr  = 0;
  logic [31:0] fw[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (load_en_a === 1'b1) begin
      n_wr++;
      if (sb.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_data_a", inst_a, e.data);
        check("wr_addr_a", addr_a, 32'h0000_0000 + 32'(e.idx) * 4);
        check("wr_en_b", {31'd0, load_en_b}, 32'd1);
        check("wr_data_b", inst_b, e.data);
        check("wr_addr_b", addr_b, 32'h0000_0100 + 32'(e.idx) * 4);
      end
    end else if (load_en_b === 1'b1) begin
      check("unexpected_write_b", 32'd1, 32'd0);
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic check_status(input string tag, input bit bsy, input bit dn, input bit er);
    check({tag, ".busy"},       {31'd0, busy_a},       {31'd0, bsy});
    check({tag, ".done"},       {31'd0, done_a},       {31'd0, dn});
    check({tag, ".err"},        {31'd0, err_a},        {31'd0, er});
    check({tag, ".core_rst_n"}, {31'd0, core_rst_n_a}, {31'd0, dn});
    check({tag, ".done_b"},     {31'd0, done_b},       {31'd0, dn});
    check({tag, ".err_b"},      {31'd0, err_b},        {31'd0, er});
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".in_ready"},   {31'd0, in_ready_a},   32'd0);
    check({tag, ".load_en"},    {31'd0, load_en_a},    32'd0);
    check({tag, ".addr"},       addr_a,                32'd0);
    check({tag, ".inst"},       inst_a,                32'd0);
    check({tag, ".core_rst_n"}, {31'd0, core_rst_n_a}, 32'd0);
    check({tag, ".busy"},       {31'd0, busy_a},       32'd0);
    check({tag, ".done"},       {31'd0, done_a},       32'd0);
    check({tag, ".err"},        {31'd0, err_a},        32'd0);
  endtask

  // Drives a complete frame from fw[]; bad flips the checksum, maxgap adds
  // random idle cycles, probe checks the status right after the SOF byte.
  task automatic send_frame(input int n, input bit bad, input int maxgap, input bit probe);
    logic [15:0] nn;
    logic [7:0]  x;
    logic [7:0]  b;
    exp_t        e;
    nn = 16'(n);
    x  = 8'd0;
    send_byte(8'hA5);
    if (probe) begin
      check("reload.core_rst_n", {31'd0, core_rst_n_a}, 32'd0);
      check("reload.busy",       {31'd0, busy_a},       32'd1);
      check("reload.done",       {31'd0, done_a},       32'd0);
    end
    send_byte(nn[7:0]);
    x ^= nn[7:0];
    send_byte(nn[15:8]);
    x ^= nn[15:8];
    if (n > MAXW) return;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = fw[i][8*k +: 8];
        x ^= b;
        if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
        if (k == 3) begin
          e.idx  = i;
          e.data = fw[i];
          sb.push_back(e);
        end
        send_byte(b);
      end
    end
    if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
    send_byte(bad ? (x ^ 8'h01) : x);
  endtask

  initial begin
    int w0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    idle(3);
    check_reset("reset");
    rst_n = 1'b1;
    idle(1);
    check("ready_a", {31'd0, in_ready_a}, 32'd1);
    check("ready_b", {31'd0, in_ready_b}, 32'd1);

    // Normal two-word load.
    fw[0] = 32'h0000_0013; fw[1] = 32'h0010_0093; fw[2] = 32'd0; fw[3] = 32'd0;
    w0 = n_wr;
    send_frame(2, 1'b0, 0, 1'b0);
    check_status("normal", 1'b0, 1'b1, 1'b0);
    idle(2);
    check("normal.writes", 32'(n_wr - w0), 32'd2);

    // Reload after DONE with a bad checksum.
    w0 = n_wr;
    send_frame(2, 1'b1, 0, 1'b1);
    check_status("badchk", 1'b0, 1'b0, 1'b1);
    idle(2);
    check("badchk.writes", 32'(n_wr - w0), 32'd2);

    // Empty frame.
    w0 = n_wr;
    send_frame(0, 1'b0, 0, 1'b0);
    check_status("empty", 1'b0, 1'b1, 1'b0);
    idle(2);
    check("empty.writes", 32'(n_wr - w0), 32'd0);

    // Oversize frame rejected right after LEN_HI.
    w0 = n_wr;
    send_frame(MAXW + 1, 1'b0, 0, 1'b0);
    check_status("oversize", 1'b0, 1'b0, 1'b1);
    idle(4);
    check("oversize.writes", 32'(n_wr - w0), 32'd0);

    // Junk outside a frame is dropped.
    send_byte(8'h11);
    send_byte(8'h22);
    check_status("junk", 1'b0, 1'b0, 1'b1);

    // Gapped stream with SOF-valued data bytes.
    fw[0] = 32'hA512_A534; fw[1] = 32'hA5A5_A5A5; fw[2] = 32'h00A5_0001; fw[3] = 32'hDEAD_BEEF;
    w0 = n_wr;
    send_frame(4, 1'b0, 3, 1'b0);
    check_status("gaps", 1'b0, 1'b1, 1'b0);
    idle(2);
    check("gaps.writes", 32'(n_wr - w0), 32'd4);

    // Reset after six data bytes of a two-word frame.
    fw[0] = 32'h1122_3344; fw[1] = 32'h5566_7788;
    w0 = n_wr;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        exp_t e;
        e.idx  = 0;
        e.data = fw[0];
        sb.push_back(e);
      end
      send_byte(fw[k / 4][8*(k % 4) +: 8]);
    end
    idle(5);
    check_status("stall", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(1);
    check_reset("midreset");
    rst_n = 1'b1;
    idle(1);
    check("midreset.writes", 32'(n_wr - w0), 32'd1);
    w0 = n_wr;
    send_frame(2, 1'b0, 0, 1'b0);
    check_status("after_reset", 1'b0, 1'b1, 1'b0);
    idle(2);
    check("after_reset.writes", 32'(n_wr - w0), 32'd2);
    check("pending", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
